// File: rtl/im_loader_if.sv
// Byte-stream handshake and instruction-RAM write port of the program loader.
// master = stream source / RAM side, slave = loader.
interface im_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output byte_in, byte_valid, byte_last,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_in, byte_valid, byte_last,
    output byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a byte stream into big-endian words and
// writes them from BASE_ADDR upward, stalling the CPU until the image is in.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  im_loader_if.slave  bus,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [12:0] word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE, ERR} state_t;

  localparam logic [12:0] DEPTH_C = 13'(DEPTH);

  state_t      state, state_d;
  logic [1:0]  idx_p0;
  logic [23:0] word_p0;
  logic [31:0] ptr_p0;
  logic        fire, full_hit, wr_now, launch;
  logic [31:0] packed_w;

  assign bus.byte_ready = (state == LOAD);
  assign busy           = (state == LOAD);
  assign done           = (state == DONE);
  assign overflow       = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    launch   = 1'b0;
    fire     = bus.byte_valid && (state == LOAD);
    full_hit = (word_count == DEPTH_C);
    wr_now   = fire && !full_hit && ((idx_p0 == 2'd3) || bus.byte_last);
    // Bytes not yet received stay zero, which pads a short final word.
    case (idx_p0)
      2'd0:    packed_w = {bus.byte_in, 24'h0};
      2'd1:    packed_w = {word_p0[23:16], bus.byte_in, 16'h0};
      2'd2:    packed_w = {word_p0[23:8], bus.byte_in, 8'h0};
      default: packed_w = {word_p0, bus.byte_in};
    endcase
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LOAD;
          launch  = 1'b1;
        end
      end
      LOAD: begin
        if (fire) begin
          if (full_hit)           state_d = ERR;
          else if (bus.byte_last) state_d = DONE;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: byte accepted -> word assembly, RAM write launched next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p0       <= 2'd0;
      ptr_p0       <= BASE_ADDR;
      word_count   <= 13'd0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= 32'h0;
      bus.im_wdata <= 32'h0;
    end else begin
      bus.im_we <= 1'b0;
      if (launch) begin
        idx_p0     <= 2'd0;
        ptr_p0     <= BASE_ADDR;
        word_count <= 13'd0;
      end else if (fire && !full_hit) begin
        idx_p0 <= idx_p0 + 2'd1;
        if (wr_now) begin
          idx_p0       <= 2'd0;
          bus.im_we    <= 1'b1;
          bus.im_addr  <= ptr_p0;
          bus.im_wdata <= packed_w;
          ptr_p0       <= ptr_p0 + 32'd4;
          word_count   <= word_count + 13'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire && !full_hit) word_p0 <= packed_w[31:8];
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table vectors, corner sequences and randomized sessions
// checked against a queue-based model of the expected RAM writes.
module tb_im_loader;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid, byte_last;
  logic [7:0]  byte_in;
  logic        busy0, done0, ovf0, busy4, done4, ovf4;
  logic [12:0] wc0, wc4;

  always #5 clk = ~clk;

  im_loader_if bus0();
  im_loader_if bus4();

  assign bus0.byte_in    = byte_in;
  assign bus0.byte_valid = byte_valid;
  assign bus0.byte_last  = byte_last;
  assign bus4.byte_in    = byte_in;
  assign bus4.byte_valid = byte_valid;
  assign bus4.byte_last  = byte_last;

  im_loader #(.BASE_ADDR(BASE), .DEPTH(4096)) dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(bus0.slave),
    .busy(busy0), .done(done0), .overflow(ovf0), .word_count(wc0)
  );

  im_loader #(.BASE_ADDR(BASE), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .bus(bus4.slave),
    .busy(busy4), .done(done4), .overflow(ovf4), .word_count(wc4)
  );

  typedef struct {
    logic [63:0] bytes;
    int          n;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    int          count;
  } vec_t;

  vec_t        tbl[5];
  int          nvec = 0;
  int          nerr = 0;
  int          stalls;
  bit          sel;
  bit          lat_we, lat_done, exp_ovf;
  logic [7:0]  stim_q[$];
  logic [63:0] wq0[$], wq4[$], exp_q[$];

  always @(negedge clk) begin
    if (bus0.im_we) wq0.push_back({bus0.im_addr, bus0.im_wdata});
    if (bus4.im_we) wq4.push_back({bus4.im_addr, bus4.im_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic cur_ready();
    return sel ? bus4.byte_ready : bus0.byte_ready;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input int gapmax, input bit has_last, input bit mid_start);
    stalls = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      int g;
      int t;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start      = mid_start && (j == 0);
      end
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b1;
      byte_in    = stim_q[i];
      byte_last  = has_last && (i == stim_q.size() - 1);
      t = 0;
      while (!cur_ready() && t < 8) begin
        @(negedge clk);
        t++;
        stalls++;
      end
      if (t == 8) begin
        check("ready_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    lat_we     = sel ? bus4.im_we : bus0.im_we;
    lat_done   = sel ? done4 : done0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b0;
  endtask

  // Expected writes: consecutive groups of four bytes, MSB first, zero padded
  // at the end of the image; any byte arriving once depth words exist overflows.
  task automatic build_model(input int depth, input bit has_last);
    logic [31:0] w;
    int          k;
    exp_q.delete();
    exp_ovf = 1'b0;
    w = 32'h0;
    k = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (exp_q.size() == depth) begin
        exp_ovf = 1'b1;
        break;
      end
      w[31 - 8*k -: 8] = stim_q[i];
      k++;
      if (k == 4 || (has_last && i == stim_q.size() - 1)) begin
        exp_q.push_back({BASE + 32'(4 * exp_q.size()), w});
        w = 32'h0;
        k = 0;
      end
    end
  endtask

  task automatic compare_writes(input string tag, input bit use4);
    logic [63:0] q[$];
    q = use4 ? wq4 : wq0;
    check({tag, "_nwrites"}, 32'(q.size()), 32'(exp_q.size()));
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, q[i][63:32], exp_q[i][63:32]);
      check({tag, "_data"}, q[i][31:0],  exp_q[i][31:0]);
    end
  endtask

  initial begin
    tbl[0] = '{64'h24010005_00000000, 4, 32'h0000_3000, 32'h2401_0005, 1};
    tbl[1] = '{64'hAABBCCDD_11220000, 6, 32'h0000_3004, 32'h1122_0000, 2};
    tbl[2] = '{64'h12000000_00000000, 1, 32'h0000_3000, 32'h1200_0000, 1};
    tbl[3] = '{64'hDEADBE00_00000000, 3, 32'h0000_3000, 32'hDEAD_BE00, 1};
    tbl[4] = '{64'h01020304_05060708, 8, 32'h0000_3004, 32'h0506_0708, 2};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_ovf",   {31'd0, ovf0},  32'd0);
    check("rst_wc",    {19'd0, wc0},   32'd0);
    check("rst_ready", {31'd0, bus0.byte_ready}, 32'd0);
    check("rst_we",    {31'd0, bus0.im_we}, 32'd0);
    check("rst_addr",  bus0.im_addr,  32'd0);
    check("rst_wdata", bus0.im_wdata, 32'd0);
    start = 1'b0;
    reset = 1'b0;

    foreach (tbl[v]) begin
      stim_q.delete();
      for (int i = 0; i < tbl[v].n; i++) stim_q.push_back(tbl[v].bytes[63 - 8*i -: 8]);
      wq0.delete();
      sel = 1'b0;
      do_start();
      send(0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check("tbl_nwrites", 32'(wq0.size()), 32'(tbl[v].count));
      if (wq0.size() > 0) begin
        check("tbl_last_addr", wq0[wq0.size()-1][63:32], tbl[v].last_addr);
        check("tbl_last_data", wq0[wq0.size()-1][31:0],  tbl[v].last_data);
      end
      check("tbl_wc",       {19'd0, wc0},   32'(tbl[v].count));
      check("tbl_done",     {31'd0, done0}, 32'd1);
      check("tbl_busy",     {31'd0, busy0}, 32'd0);
      check("tbl_ovf",      {31'd0, ovf0},  32'd0);
      check("tbl_lat_we",   {31'd0, lat_we},   32'd1);
      check("tbl_lat_done", {31'd0, lat_done}, 32'd1);
      check("tbl_stalls",   32'(stalls), 32'd0);
      build_model(4096, 1'b1);
      compare_writes("tbl_model", 1'b0);
    end

    // DEPTH=4: seventeenth byte overflows with no fifth write
    sel = 1'b1;
    stim_q.delete();
    for (int i = 0; i < 17; i++) stim_q.push_back(8'(i + 1));
    wq4.delete();
    do_start();
    send(0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    build_model(4, 1'b0);
    check("ovf_model_flag", {31'd0, ovf4}, {31'd0, exp_ovf});
    compare_writes("ovf", 1'b1);
    check("ovf_last_addr", (wq4.size() > 0) ? wq4[wq4.size()-1][63:32] : 32'hx, 32'h0000_300C);
    check("ovf_flag",  {31'd0, ovf4},  32'd1);
    check("ovf_ready", {31'd0, bus4.byte_ready}, 32'd0);
    check("ovf_done",  {31'd0, done4}, 32'd0);
    check("ovf_busy",  {31'd0, busy4}, 32'd0);
    check("ovf_lat_we", {31'd0, lat_we}, 32'd0);

    // DEPTH=4: exactly four words ending with byte_last is a clean load
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
    wq4.delete();
    do_start();
    send(0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    build_model(4, 1'b1);
    compare_writes("full", 1'b1);
    check("full_ovf",  {31'd0, ovf4},  32'd0);
    check("full_done", {31'd0, done4}, 32'd1);
    check("full_wc",   {19'd0, wc4},   32'd4);

    // Reset two bytes into a word, then reload from scratch
    sel = 1'b0;
    wq0.delete();
    stim_q = '{8'h55, 8'h66};
    do_start();
    send(0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    check("mid_rst_we",   {31'd0, bus0.im_we}, 32'd0);
    check("mid_rst_addr", bus0.im_addr, 32'd0);
    check("mid_rst_wdata", bus0.im_wdata, 32'd0);
    check("mid_rst_wc",   {19'd0, wc0}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_nowrite", 32'(wq0.size()), 32'd0);
    stim_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    do_start();
    send(0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    build_model(4096, 1'b1);
    compare_writes("reload", 1'b0);
    check("reload_data", (wq0.size() > 0) ? wq0[0][31:0] : 32'hx, 32'hC1C2_C3C4);

    // Randomized sessions with valid gaps and stray start pulses
    for (int s = 0; s < 12; s++) begin
      int n;
      n = int'($urandom_range(24, 1));
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
      wq0.delete();
      do_start();
      send(3, 1'b1, s[0]);
      repeat (2) @(negedge clk);
      build_model(4096, 1'b1);
      compare_writes("rand", 1'b0);
      check("rand_wc",   {19'd0, wc0},   32'(exp_q.size()));
      check("rand_done", {31'd0, done0}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Write-side counterpart of the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one-cycle write strobes into the instruction RAM, starting at the text-segment base address.
- Holds the CPU in stall (busy) until the program image is fully loaded.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first instruction word.
- DEPTH, 4096, capacity in 32-bit words; addresses BASE_ADDR to BASE_ADDR + 4*DEPTH - 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_last  input  1  qualifies the final byte of the image; sampled with byte_valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  one-cycle write strobe to the instruction RAM.
- im_addr  output  32  byte address of the write, word aligned.
- im_wdata  output  32  instruction word.
- busy  output  1  a session is in progress; drives CPU stall.
- done  output  1  image loaded successfully; held until the next start.
- overflow  output  1  image exceeded DEPTH; held until the next start.
- word_count  output  13  words written in the current or last session.

Behaviour:
- Reset: state IDLE.
  - All outputs 0: byte_ready, im_we, im_addr, im_wdata, busy, done, overflow, word_count.
  - Internal byte index 0; write pointer BASE_ADDR.
  - Reset mid-session aborts immediately, with no further im_we.
- States: IDLE, LOAD, FLUSH, DONE, ERR.
- IDLE / DONE / ERR:
  - byte_ready=0, busy=0.
  - start=1 -> LOAD; clears done, overflow, word_count, byte index; write pointer = BASE_ADDR.
- LOAD:
  - busy=1; byte_ready=1 (combinational from state only, never from byte_valid).
  - Handshake fires when byte_valid & byte_ready. Bytes without byte_ready are not consumed.
  - Byte packing: byte index 0 -> bits [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Handshake on index 3: at that edge, im_we<=1, im_wdata<=assembled word, im_addr<=write pointer; pointer +=4; word_count +=1; index wraps to 0.
  - im_we is high for exactly the following cycle. Latency: final byte accepted at edge N -> im_we high during cycle N+1.
  - byte_last on a full word (index 3): write as above, then -> DONE; done=1 from the same edge im_we rises.
  - byte_last on a partial word (index 0–2): unfilled low bytes are 0x00; write issued identically, then -> DONE.
  - Overflow: handshake when word_count == DEPTH -> ERR; overflow=1; no im_we; byte discarded.
    - Image of exactly DEPTH words ending with byte_last is not overflow.
  - start during LOAD is ignored.
  - byte_valid=0 in LOAD: state holds indefinitely; partially assembled word retained.
- FLUSH: reserved encoding. Never entered; if reached, returns to IDLE next cycle.
- im_addr and im_wdata hold their last values when im_we=0.
- Increments are 32-bit wrap-free; with DEPTH bounded, the pointer never passes BASE_ADDR + 4*DEPTH.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset then start; bytes 24,01,00,05 with byte_last on the 4th -> single im_we cycle, im_addr=0x00003000, im_wdata=0x24010005; done=1; word_count=1; busy=0.
- Two words back to back, byte_valid continuously high -> im_we at 0x00003000 then 0x00003004, one cycle each, data in order; byte_ready never drops in LOAD.
- Six bytes AA,BB,CC,DD,11,22 with byte_last on 22 -> second write im_addr=0x00003004, im_wdata=0x11220000; word_count=2.
- DEPTH=4 override, 17 bytes with no byte_last -> four writes (last at 0x0000300C), then overflow=1 and state ERR on byte 17, no fifth im_we, byte_ready=0.
- Reset asserted after 2 bytes of a word -> all outputs 0 next cycle; new start plus 4 bytes -> write at 0x00003000 containing only the new bytes.
- byte_valid gaps of random 0–3 cycles, plus a start pulse mid-LOAD -> data and addresses identical to the gap-free run; start has no effect.
